// File: rtl/challenge_generator.sv
// LFSR challenge source for the PUF input network: N_CHAL challenges per run over valid/ready, then a done pulse.
// Optional macro CHAL_REPEAT_EN: each challenge is transferred REPEAT times before the LFSR steps.
module challenge_generator #(
   parameter int              N_CB     = 32,
   parameter logic [N_CB-1:0] TAPS     = 32'h80200003,
   parameter logic [N_CB-1:0] SEED_DEF = 32'h00000001,
   parameter int              N_CHAL   = 1000,
   parameter int              CNT_W    = 16,
   parameter int              REPEAT   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             seed_load_i,
   input  logic [N_CB-1:0]  seed_i,
   output logic [N_CB-1:0]  chal_o,
   output logic             chal_valid_o,
   input  logic             chal_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] chal_count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHAL - 1);
   localparam bit               NO_CHAL  = (N_CHAL == 0);

   state_t            state_q, state_d;
   logic [N_CB-1:0]   lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              xfer;
   logic              last_rep;
   logic [N_CB-1:0]   lfsr_step;

`ifdef CHAL_REPEAT_EN
   localparam int               REP_W    = $clog2(REPEAT + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
   logic [REP_W-1:0] rep_q, rep_d;

   assign last_rep = (rep_q == REP_LAST);
`else
   logic unused_repeat;

   assign unused_repeat = (REPEAT > 0);
   assign last_rep      = 1'b1;
`endif

   assign lfsr_step = {lfsr_q[N_CB-2:0], ^(lfsr_q & TAPS)};
   assign xfer      = (state_q == ISSUE) && chal_ready_i;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
`ifdef CHAL_REPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         IDLE: begin
            // A same-cycle seed load takes effect before the run's first challenge.
            if (seed_load_i) begin
               lfsr_d = (seed_i == '0) ? N_CB'(1) : seed_i;
            end
            if (start_i) begin
               cnt_d   = '0;
`ifdef CHAL_REPEAT_EN
               rep_d   = '0;
`endif
               state_d = NO_CHAL ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (xfer) begin
               if (last_rep) begin
                  lfsr_d = lfsr_step;
                  cnt_d  = cnt_q + 1'b1;
`ifdef CHAL_REPEAT_EN
                  rep_d  = '0;
`endif
                  if (cnt_q == CNT_LAST) begin
                     state_d = DONE;
                  end
               end
`ifdef CHAL_REPEAT_EN
               else begin
                  rep_d = rep_q + 1'b1;
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_DEF;
         cnt_q   <= '0;
`ifdef CHAL_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
`ifdef CHAL_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   assign chal_o       = lfsr_q;
   assign chal_valid_o = (state_q == ISSUE);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign chal_count_o = cnt_q;

endmodule

// File: tb/tb_challenge_generator.sv
// Bench for challenge_generator: seed/start vector table, random-backpressure runs against a transfer-level model, mid-run reset.
module tb_challenge_generator;

   localparam int          N_CB     = 32;
   localparam int          N_CHAL   = 20;
   localparam int          CNT_W    = 16;
   localparam logic [31:0] TAPS     = 32'h80200003;
   localparam logic [31:0] SEED_DEF = 32'h00000001;
`ifdef CHAL_REPEAT_EN
   localparam int          REP      = 4;
`else
   localparam int          REP      = 1;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             seed_load_i = 1'b0;
   logic [N_CB-1:0]  seed_i = '0;
   logic [N_CB-1:0]  chal_o;
   logic             chal_valid_o;
   logic             chal_ready_i = 1'b0;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] chal_count_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_lfsr;
   int          m_cnt;
   int          m_rep;

   challenge_generator #(
      .N_CB(N_CB), .TAPS(TAPS), .SEED_DEF(SEED_DEF),
      .N_CHAL(N_CHAL), .CNT_W(CNT_W), .REPEAT(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .seed_load_i(seed_load_i),
      .seed_i(seed_i), .chal_o(chal_o), .chal_valid_o(chal_valid_o),
      .chal_ready_i(chal_ready_i), .busy_o(busy_o), .done_o(done_o),
      .chal_count_o(chal_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        load;
      logic [31:0] seed;
      logic        start;
      logic [31:0] exp_chal;
      logic        exp_valid;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Feedback is the parity of the tapped bits, shifted in at bit 0.
   function automatic logic [31:0] ref_next(input logic [31:0] x);
      int ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (TAPS[i] && x[i]) ones++;
      end
      return {x[30:0], 1'b0} | 32'(ones % 2);
   endfunction

   task automatic model_xfer();
      m_rep++;
      if (m_rep == REP) begin
         m_rep  = 0;
         m_lfsr = ref_next(m_lfsr);
         m_cnt++;
      end
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      m_cnt = 0;
      m_rep = 0;
   endtask

   // Runs until the model has seen N_CHAL challenges complete; checks every cycle.
   task automatic run_and_check(input bit rnd, input int hold_at);
      int cyc = 0;
      int xfers = 0;
      bit r;
      while (m_cnt < N_CHAL && cyc < 5000) begin
         chk("run_chal", chal_o, m_lfsr);
         chk("run_valid", chal_valid_o, 1);
         chk("run_count", chal_count_o, m_cnt);
         chk("run_done", done_o, 0);
         r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (cyc >= hold_at && cyc < hold_at + 5) r = 1'b0;
         chal_ready_i = r;
         tick();
         if (r) begin
            model_xfer();
            xfers++;
         end
         cyc++;
      end
      chal_ready_i = 1'b0;
      chk("run_timeout", (cyc >= 5000), 0);
      chk("run_xfers", xfers, N_CHAL * REP);
      chk("end_done", done_o, 1);
      chk("end_valid", chal_valid_o, 0);
      chk("end_busy", busy_o, 1);
      chk("end_count", chal_count_o, N_CHAL);
      chk("end_chal", chal_o, m_lfsr);
      tick();
      chk("idle_done", done_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_count", chal_count_o, N_CHAL);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 32'h00000005, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};

      tick();
      tick();
      rst_i = 1'b0;
      chk("rst_chal", chal_o, SEED_DEF);
      chk("rst_valid", chal_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_count", chal_count_o, 0);

      // Seed handling in IDLE, then seed+start together, then ignored inputs while busy.
      for (int i = 0; i < 7; i++) begin
         seed_load_i = vecs[i].load;
         seed_i      = vecs[i].seed;
         start_i     = vecs[i].start;
         tick();
         chk($sformatf("vec%0d_chal", i), chal_o, vecs[i].exp_chal);
         chk($sformatf("vec%0d_valid", i), chal_valid_o, vecs[i].exp_valid);
         chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
      end
      seed_load_i = 1'b0;
      start_i     = 1'b0;
      m_lfsr = 32'hDEADBEEF;
      m_cnt  = 0;
      m_rep  = 0;
      run_and_check(1'b1, 3);

      // Fresh sequence from the reset seed at full throughput with a 5-cycle stall.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      m_lfsr = SEED_DEF;
      do_start();
      chk("t1_first", chal_o, 32'h00000001);
      run_and_check(1'b0, 6);

      // Next run continues the LFSR sequence without reseeding.
      do_start();
      chk("cont_first", chal_o, m_lfsr);
      run_and_check(1'b1, 9);

      // Mid-run reset with ignored start/seed_load pulses.
      do_start();
      chal_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("mid_chal", chal_o, m_lfsr);
         chk("mid_count", chal_count_o, m_cnt);
         start_i     = (i == 4);
         seed_load_i = (i == 4);
         seed_i      = 32'hABCD0123;
         tick();
         model_xfer();
      end
      start_i     = 1'b0;
      seed_load_i = 1'b0;
      chk("pre_rst_chal", chal_o, m_lfsr);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mrst_valid", chal_valid_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_chal", chal_o, SEED_DEF);
      chk("mrst_count", chal_count_o, 0);
      chk("mrst_done", done_o, 0);
      chal_ready_i = 1'b0;
      tick();
      chk("mrst_idle_valid", chal_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
